board_io_bridge: RTL and testbench
==================================

Name: board_io_bridge

Overview:
Registered board-I/O bridge between DE2-class pins (KEY, SW, HEX) and the SoC GPIO ports. It synchronises and debounces KEY/SW and latches sticky key-press events. It builds the 32-bit GPIO input word for the SoC and drives a parametrised number of 7-segment digits from a SoC-supplied value, with selectable display modes. It replaces the tie-offs and the direct KEY/SW concatenation in the board top level.

Parameters:
clk_mhz, 50, clock frequency in MHz.
w_key, 4, number of push buttons (active-low pins).
w_sw, 18, number of slide switches.
w_hex, 8, number of 7-segment digits.
db_tick_cycles, clk_mhz*1000, clock cycles per debounce sample tick (1 ms at default); must be >= 2.
db_samples, 4, consecutive disagreeing ticks required to accept a new level; range 1..15.

Ports:
CLOCK_50  in  1  sole clock; all state is on its rising edge.
RESET_N  in  1  asynchronous, active-low reset.
KEY  in  w_key  raw buttons, active-low, asynchronous.
SW  in  w_sw  raw switches, asynchronous.
evt_clr  in  w_key  per-key single-cycle clear of the sticky press events.
hex_mode  in  2  0 = blank, 1 = hex, 2 = hex with leading-zero blanking, 3 = blank.
hex_value  in  4*w_hex  nibble i is shown on digit i.
gpio_in  out  32  {zero pad, key_event, key_level, sw_level} to the SoC GPIO input.
HEX  out  7*w_hex  segment lines, active-low; digit i occupies bits [7i+6:7i], with segment g as the MSB.

Behaviour:
- Elaboration check: 2*w_key + w_sw <= 32, otherwise a fatal error.
- Reset (RESET_N=0, asynchronous) sets the following:
  - KEY sync flops to 1; SW sync flops to 0.
  - Debounced KEY to 1; debounced SW to 0.
  - All debounce counters and the tick counter to 0.
  - key_event to 0.
  - gpio_in = 0; HEX = all 1s.
- Synchroniser: 2 flops per bit.
- Tick counter: counts 0..db_tick_cycles-1 and wraps. The tick is asserted for exactly one cycle when the count equals db_tick_cycles-1.
- Per-bit debounce, evaluated only on tick cycles:
  - If the synced bit differs from the debounced bit, cnt increments.
  - When cnt reaches db_samples-1 on a differing tick, the debounced bit takes the synced value and cnt returns to 0.
  - If the synced bit equals the debounced bit, cnt returns to 0.
  - Off-tick cycles hold all state.
- key_level[i] = ~debounced KEY[i], i.e. 1 while the button is pressed.
- Press event:
  - When the debounced KEY[i] goes 1->0, key_event[i] sets on the following edge.
  - evt_clr[i]=1 clears it.
  - If a set and a clear land on the same cycle, the set wins.
  - Events are sticky; repeated presses do not count.
- gpio_in is registered. It reflects key_level, key_event and sw_level one cycle after they change. Bits above 2*w_key+w_sw are 0.
- HEX output:
  - hex_value and hex_mode are registered, then decoded and registered again, giving a latency of 2 cycles.
  - Encodings: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
  - Mode 2 blanks (all 1s) every digit above the most significant non-zero nibble. Digit 0 is always shown, so a value of 0 displays a single "0".
  - Modes 0 and 3 produce all 1s.
- Worst-case accept latency from a pin change: 2 sync cycles + db_samples ticks + 1 gpio_in register cycle.
- Reset asserted mid-debounce abandons the count; after release, the outputs equal their reset values.

Test Plan:
All scenarios use db_tick_cycles=4, db_samples=3, w_hex=8.
1. Reset -> gpio_in=0 and HEX=all 1s while RESET_N=0; both unchanged for 5 cycles after release with KEY=4'hF and SW=0.
2. SW[0] 0->1, held -> gpio_in[0]=1 no later than 2+12+1 cycles after the change; a 6-cycle glitch on SW[1] never appears in gpio_in.
3. KEY[2] pressed (0) for 40 cycles then released -> key_level bit 2 (gpio_in[20]) is 1 during the press; key_event bit 2 (gpio_in[24]) is 1 and stays 1 after release. evt_clr=4'b0100 for one cycle -> gpio_in[24]=0.
4. evt_clr[2] asserted on the same cycle key_event[2] sets -> gpio_in[24]=1.
5. hex_mode=1, hex_value=32'h0000_A05F -> 2 cycles later HEX[6:0]=0001110, HEX[13:7]=0010010, HEX[20:14]=1000000, HEX[27:21]=0001000, and digits 4-7 show 1000000.
6. hex_mode=2 with the same value -> digits 4-7 show all 1s and digits 0-3 are unchanged. hex_value=0 -> digit 0 shows 1000000 and all other digits show all 1s.

Source files
------------

// File: rtl/board_io_bridge_if.sv
// SoC-side GPIO/display port bundle of the board I/O bridge.
// No valid/ready handshake: every signal is sampled each cycle, evt_clr is a one-cycle pulse per key.
interface board_io_bridge_if #(
  parameter int w_key = 4,
  parameter int w_hex = 8
);
  logic [w_key-1:0]   evt_clr;
  logic [1:0]         hex_mode;
  logic [4*w_hex-1:0] hex_value;
  logic [31:0]        gpio_in;

  modport master (output evt_clr, output hex_mode, output hex_value, input gpio_in);
  modport slave  (input evt_clr, input hex_mode, input hex_value, output gpio_in);
endinterface

// File: rtl/board_io_bridge.sv
// Board I/O bridge: synchronises and debounces KEY/SW, latches sticky key presses,
// builds the SoC GPIO input word and drives the 7-segment digits.
module board_io_bridge #(
  parameter int clk_mhz        = 50,
  parameter int w_key          = 4,
  parameter int w_sw           = 18,
  parameter int w_hex          = 8,
  parameter int db_tick_cycles = clk_mhz * 1000,
  parameter int db_samples     = 4
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic [w_key-1:0]   KEY,
  input  logic [w_sw-1:0]    SW,
  output logic [7*w_hex-1:0] HEX,
  board_io_bridge_if.slave   soc
);

  localparam int w_in = w_key + w_sw;
  localparam int tw   = (db_tick_cycles > 1) ? $clog2(db_tick_cycles) : 1;
  // Keys idle high (active-low buttons), switches idle low.
  localparam logic [w_in-1:0] in_rst = {{w_sw{1'b0}}, {w_key{1'b1}}};

  if (2*w_key + w_sw > 32) begin : g_bad_width
    $fatal(1, "board_io_bridge: 2*w_key + w_sw must not exceed 32");
  end
  if (db_samples < 1 || db_samples > 15) begin : g_bad_samples
    $fatal(1, "board_io_bridge: db_samples must be in 1..15");
  end
  if (db_tick_cycles < 2) begin : g_bad_tick
    $fatal(1, "board_io_bridge: db_tick_cycles must be at least 2");
  end

  logic [w_in-1:0]  raw;
  logic [w_in-1:0]  sync1;
  logic [w_in-1:0]  sync2;
  logic [w_in-1:0]  deb;
  logic [3:0]       cnt [w_in];
  logic [tw-1:0]    tick_cnt;
  logic             tick;
  logic [w_key-1:0] deb_key_q;
  logic [w_key-1:0] key_fall;
  logic [w_key-1:0] key_event;

  assign raw = {SW, KEY};

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= in_rst;
      sync2 <= in_rst;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign tick = (tick_cnt == tw'(db_tick_cycles - 1));

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)  tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + tw'(1);
  end

  // A new level is accepted only after db_samples consecutive disagreeing ticks.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      deb <= in_rst;
      for (int i = 0; i < w_in; i++) cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < w_in; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == 4'(db_samples - 1)) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 4'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign key_fall = deb_key_q & ~deb[w_key-1:0];

  // Set has priority over clear so a press landing on a clear is never lost.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      deb_key_q <= '1;
      key_event <= '0;
    end else begin
      deb_key_q <= deb[w_key-1:0];
      key_event <= (key_event & ~soc.evt_clr) | key_fall;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) soc.gpio_in <= '0;
    else          soc.gpio_in <= 32'({key_event, ~deb[w_key-1:0], deb[w_in-1:w_key]});
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [4*w_hex-1:0] hex_val_q;
  logic [1:0]         hex_mode_q;
  logic [7*w_hex-1:0] seg_d;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      hex_val_q  <= '0;
      hex_mode_q <= 2'd0;
    end else begin
      hex_val_q  <= soc.hex_value;
      hex_mode_q <= soc.hex_mode;
    end
  end

  // Scan from the top digit down; 'seen' goes high at the first non-zero nibble.
  always_comb begin
    logic       seen;
    logic [3:0] nib;
    seg_d = '1;
    seen  = 1'b0;
    nib   = 4'h0;
    for (int i = w_hex - 1; i >= 0; i--) begin
      nib  = hex_val_q[4*i +: 4];
      seen = seen | (nib != 4'h0);
      case (hex_mode_q)
        2'd1:    seg_d[7*i +: 7] = seg7(nib);
        2'd2:    if (seen || i == 0) seg_d[7*i +: 7] = seg7(nib);
        default: seg_d[7*i +: 7] = 7'h7F;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) HEX <= '1;
    else          HEX <= seg_d;
  end

endmodule

// File: tb/tb_board_io_bridge.sv
// Directed bench for board_io_bridge: stimulus pushes expectations, a monitor pops and checks them.
module tb_board_io_bridge;
  localparam int w_key = 4;
  localparam int w_sw  = 18;
  localparam int w_hex = 8;

  localparam int m_within = 0;  // must match at some sample within 'cycles'
  localparam int m_hold   = 1;  // must match on 'cycles' consecutive samples
  localparam int m_at     = 2;  // must match exactly after 'cycles' samples

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [w_key-1:0]   key;
  logic [w_sw-1:0]    sw;
  logic [7*w_hex-1:0] hex;

  board_io_bridge_if #(.w_key(w_key), .w_hex(w_hex)) soc ();

  board_io_bridge #(
    .clk_mhz(50), .w_key(w_key), .w_sw(w_sw), .w_hex(w_hex),
    .db_tick_cycles(4), .db_samples(3)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key), .SW(sw), .HEX(hex), .soc(soc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    int          mode;
    logic [55:0] mask;
    logic [55:0] val;
    int          cycles;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  bit    mon_busy = 1'b0;
  int    tests = 0;
  int    fails = 0;

  function automatic logic [55:0] sample(input int sel);
    return (sel == 0) ? {24'd0, soc.gpio_in} : hex;
  endfunction

  task automatic expect_gpio(input string nm, input int mode, input logic [31:0] mask,
                             input logic [31:0] val, input int cycles);
    exp_t e;
    e.sel = 0; e.mode = mode; e.mask = {24'd0, mask}; e.val = {24'd0, val}; e.cycles = cycles;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic expect_hex(input string nm, input int mode, input logic [55:0] val,
                            input int cycles);
    exp_t e;
    e.sel = 1; e.mode = mode; e.mask = '1; e.val = val; e.cycles = cycles;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((exp_q.size() != 0 || mon_busy) && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 400) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: monitor still had %0d checks pending, required 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
    #1;
  endtask

  task automatic hex_step(input string nm, input logic [1:0] m, input logic [31:0] v,
                          input logic [55:0] prev, input logic [55:0] expv);
    soc.hex_mode  = m;
    soc.hex_value = v;
    expect_hex({nm, "_latency"}, m_hold, prev, 2);
    expect_hex(nm, m_at, expv, 0);
    wait_idle();
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    exp_t        e;
    string       nm;
    logic [55:0] act;
    logic [55:0] a;
    bit          ok;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_busy = 1'b1;
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        ok  = 1'b1;
        act = '0;
        case (e.mode)
          m_within: begin
            ok = 1'b0;
            for (int c = 0; c <= e.cycles; c++) begin
              act = sample(e.sel);
              if ((act & e.mask) == e.val) begin
                ok = 1'b1;
                break;
              end
              if (c < e.cycles) @(negedge clk);
            end
          end
          m_hold: begin
            for (int c = 0; c < e.cycles; c++) begin
              a = sample(e.sel);
              if (ok) act = a;
              if ((a & e.mask) != e.val) ok = 1'b0;
              if (c < e.cycles - 1) @(negedge clk);
            end
          end
          default: begin
            repeat (e.cycles) @(negedge clk);
            act = sample(e.sel);
            ok  = ((act & e.mask) == e.val);
          end
        endcase
        tests++;
        if (!ok) begin
          fails++;
          $display("FAIL %s: got %h (mask %h), required %h", nm, act & e.mask, e.mask, e.val);
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

  localparam logic [55:0] all_off = '1;
  localparam logic [55:0] exp_a05f =
    {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000,
     7'b0001000, 7'b1000000, 7'b0010010, 7'b0001110};
  localparam logic [55:0] exp_a05f_lzb =
    {{4{7'b1111111}}, 7'b0001000, 7'b1000000, 7'b0010010, 7'b0001110};
  localparam logic [55:0] exp_zero_lzb = {{7{7'b1111111}}, 7'b1000000};
  localparam logic [55:0] exp_1e7_lzb  = {7'b1111001, {7{7'b1000000}}};
  localparam logic [55:0] exp_12345678 =
    {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
     7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000};
  localparam logic [55:0] exp_9abcdef0 =
    {7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110,
     7'b0100001, 7'b0000110, 7'b0001110, 7'b1000000};

  initial begin
    key = 4'hF;
    sw  = '0;
    soc.evt_clr   = '0;
    soc.hex_mode  = 2'd0;
    soc.hex_value = '0;
    rst_n = 1'b0;
    step(1);

    // Reset values, during and after reset.
    expect_gpio("reset_gpio", m_hold, 32'hFFFF_FFFF, 32'h0, 3);
    expect_hex("reset_hex", m_hold, all_off, 3);
    wait_idle();
    rst_n = 1'b1;
    expect_gpio("post_reset_gpio", m_hold, 32'hFFFF_FFFF, 32'h0, 5);
    expect_hex("post_reset_hex", m_hold, all_off, 5);
    wait_idle();

    // Switch accept and glitch rejection.
    sw[0] = 1'b1;
    expect_gpio("sw0_accept", m_within, 32'h1, 32'h1, 15);
    wait_idle();
    sw[1] = 1'b1;
    expect_gpio("sw1_glitch_rejected", m_hold, 32'h3, 32'h1, 30);
    step(6);
    sw[1] = 1'b0;
    wait_idle();

    // Key press: level, sticky event, clear.
    key[2] = 1'b0;
    expect_gpio("key2_level", m_within, 32'h1 << 20, 32'h1 << 20, 15);
    expect_gpio("key2_event", m_within, 32'h1 << 24, 32'h1 << 24, 3);
    expect_gpio("key2_held", m_hold, 32'h1 << 20, 32'h1 << 20, 10);
    step(40);
    wait_idle();
    key[2] = 1'b1;
    expect_gpio("key2_release", m_within, (32'h1 << 20) | (32'h1 << 24), 32'h1 << 24, 15);
    expect_gpio("event_sticky", m_hold, 32'h1 << 24, 32'h1 << 24, 5);
    wait_idle();
    soc.evt_clr = 4'b0100;
    step(1);
    soc.evt_clr = 4'b0000;
    expect_gpio("evt_clr", m_within, 32'h1 << 24, 32'h0, 3);
    wait_idle();

    // Clear held high while the press lands: the set still shows for a cycle.
    soc.evt_clr = 4'b0100;
    key[2] = 1'b0;
    expect_gpio("set_wins_over_clr", m_within, 32'h1 << 24, 32'h1 << 24, 20);
    wait_idle();
    soc.evt_clr = 4'b0000;
    expect_gpio("clr_after_pulse", m_hold, (32'h1 << 20) | (32'h1 << 24), 32'h1 << 20, 5);
    wait_idle();
    key[2] = 1'b1;
    expect_gpio("key2_release2", m_within, (32'h1 << 20) | (32'h1 << 24), 32'h0, 15);
    wait_idle();

    // Display modes with exact 2-cycle latency.
    hex_step("hex_mode1_a05f", 2'd1, 32'h0000_A05F, all_off, exp_a05f);
    hex_step("hex_mode2_a05f", 2'd2, 32'h0000_A05F, exp_a05f, exp_a05f_lzb);
    hex_step("hex_mode2_zero", 2'd2, 32'h0000_0000, exp_a05f_lzb, exp_zero_lzb);
    hex_step("hex_mode2_top", 2'd2, 32'h1000_0000, exp_zero_lzb, exp_1e7_lzb);
    hex_step("hex_mode1_1to8", 2'd1, 32'h1234_5678, exp_1e7_lzb, exp_12345678);
    hex_step("hex_mode1_9to0", 2'd1, 32'h9ABC_DEF0, exp_12345678, exp_9abcdef0);
    hex_step("hex_mode3_blank", 2'd3, 32'h9ABC_DEF0, exp_9abcdef0, all_off);

    // Reset in the middle of a debounce count.
    sw[2] = 1'b1;
    step(8);
    rst_n = 1'b0;
    sw = '0;
    soc.hex_mode = 2'd0;
    step(2);
    rst_n = 1'b1;
    expect_gpio("mid_reset_gpio", m_hold, 32'hFFFF_FFFF, 32'h0, 20);
    expect_hex("mid_reset_hex", m_hold, all_off, 5);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
